// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, CLKS_PER_BIT clocks per bit.
// Two-flop input synchroniser, mid-bit sampling, one-cycle valid/error strobes.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_serial_pin,
    output logic [7:0] out_rx_byte,
    output logic       out_rx_data_valid,
    output logic       out_rx_active,
    output logic       out_frame_error,
    output logic       out_parity_error
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t           state, state_n;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift_reg, shift_n;
    logic [7:0]       byte_n;
    logic             valid_n, active_n, ferr_n, perr_n;
    logic             par_err_c;

`ifdef UART_RX_PARITY_EN
    logic             par_bit, par_bit_n;

    // Even parity: data bits plus parity bit must XOR to zero
    assign par_err_c = ^{shift_reg, par_bit};
`else
    assign par_err_c = 1'b0;
`endif

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta           <= 1'b1;
            rx_s              <= 1'b1;
            state             <= S_IDLE;
            clk_cnt           <= '0;
            bit_idx           <= '0;
            shift_reg         <= '0;
            out_rx_byte       <= '0;
            out_rx_data_valid <= 1'b0;
            out_rx_active     <= 1'b0;
            out_frame_error   <= 1'b0;
            out_parity_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit           <= 1'b0;
`endif
        end else begin
            rx_meta           <= in_serial_pin;
            rx_s              <= rx_meta;
            state             <= state_n;
            clk_cnt           <= clk_cnt_n;
            bit_idx           <= bit_idx_n;
            shift_reg         <= shift_n;
            out_rx_byte       <= byte_n;
            out_rx_data_valid <= valid_n;
            out_rx_active     <= active_n;
            out_frame_error   <= ferr_n;
            out_parity_error  <= perr_n;
`ifdef UART_RX_PARITY_EN
            par_bit           <= par_bit_n;
`endif
        end
    end

    // Next-state, counter and strobe decode
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        byte_n    = out_rx_byte;
        valid_n   = 1'b0;
        active_n  = out_rx_active;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
`endif
        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                bit_idx_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (clk_cnt == HALF_CNT) begin
                    clk_cnt_n = '0;
                    if (!rx_s) begin
                        active_n = 1'b1;
                        state_n  = S_DATA;
                    end else begin
                        state_n  = S_IDLE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_n        = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n   = S_PARITY;
`else
                        state_n   = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_n = '0;
                    par_bit_n = rx_s;
                    state_n   = S_STOP;
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_n = '0;
                    active_n  = 1'b0;
                    perr_n    = par_err_c;
                    ferr_n    = !rx_s;
                    if (rx_s && !par_err_c) begin
                        byte_n  = shift_reg;
                        valid_n = 1'b1;
                    end
                    state_n   = S_CLEANUP;
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
            S_CLEANUP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
